rho_inv_serial: RTL

Column-serial inverse rho layer for the SWAN256 decryption datapath. The block accepts one 128-bit branch as four 32-bit columns over a valid/ready stream. It computes t = a0^a1^a2^a3 and returns b_i = a_i ^ t, also column by column. Rho is an involution, so this is also the exact inverse of the parallel rho layer. It lets area-reduced round cores on the decryption side work on columns instead of a full 128-bit branch.

---
 rtl/swan_pkg.sv | 17 +
 rtl/rho_col_bank.sv | 68 ++++++
 rtl/rho_inv_serial.sv | 104 ++++++++++
 3 files changed

// File: rtl/swan_pkg.sv
// Shared SWAN256 types for the column-serial rho datapath.
// Holds block/branch/column sizes, column and index types, bank states.
package swan_pkg;

  localparam int BLOCK_SIZE  = 256;
  localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int COLUMN_SIZE = SIDE_SIZE / 4;

  typedef logic [COLUMN_SIZE-1:0] col_t;
  typedef logic [1:0]             idx_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } bank_st_t;

endpackage

// File: rtl/rho_col_bank.sv
// One column bank: 4-column store, write/read counters, t accumulator.
// Loads four columns, then replays them xored with the frozen t.
module rho_col_bank
  import swan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic wr_en,
  input  logic [COLUMN_SIZE-1:0] wr_data,
  input  logic rd_en,
  output logic emit,
  output logic wr_last,
  output logic rd_last,
  output logic [COLUMN_SIZE-1:0] rd_data,
  output idx_t rd_idx
);

  bank_st_t st;
  col_t     store [4];
  col_t     t_acc;
  idx_t     wcnt;
  idx_t     rcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= LOAD;
      wcnt  <= '0;
      rcnt  <= '0;
      t_acc <= '0;
      store <= '{default: '0};
    end else if (flush) begin
      st    <= LOAD;
      wcnt  <= '0;
      rcnt  <= '0;
      t_acc <= '0;
    end else begin
      unique case (st)
        LOAD: begin
          if (wr_en) begin
            store[wcnt] <= wr_data;
            t_acc       <= t_acc ^ wr_data;
            wcnt        <= wcnt + 2'd1;
            if (wcnt == 2'd3) st <= EMIT;
          end
        end
        EMIT: begin
          if (rd_en) begin
            rcnt <= rcnt + 2'd1;
            if (rcnt == 2'd3) begin
              st    <= LOAD;
              t_acc <= '0;
            end
          end
        end
        default: st <= LOAD;
      endcase
    end
  end

  // t_acc is frozen while in EMIT, so this is the final t
  assign emit    = (st == EMIT);
  assign wr_last = (wcnt == 2'd3);
  assign rd_last = (rcnt == 2'd3);
  assign rd_data = store[rcnt] ^ t_acc;
  assign rd_idx  = rcnt;

endmodule

// File: rtl/rho_inv_serial.sv
// Column-serial inverse rho layer (b_i = a_i ^ a0^a1^a2^a3).
// RHO_INV_PINGPONG_EN selects two banks loading/draining concurrently.
module rho_inv_serial
  import swan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [COLUMN_SIZE-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [COLUMN_SIZE-1:0] out_data,
  output logic [1:0] out_idx,
  output logic out_last
);

`ifdef RHO_INV_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [NB-1:0] emit;
  logic [NB-1:0] wr_last;
  logic [NB-1:0] rd_last;
  logic [NB-1:0] wr_en;
  logic [NB-1:0] rd_en;
  col_t          rd_data [NB];
  idx_t          rd_idx  [NB];

  logic in_fire;
  logic out_fire;
  logic sel_emit;
  col_t sel_data;
  idx_t sel_idx;

  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = sel_emit && out_ready && !flush;

  for (genvar g = 0; g < NB; g++) begin : g_bank
    rho_col_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (wr_en[g]),
      .wr_data (in_data),
      .rd_en   (rd_en[g]),
      .emit    (emit[g]),
      .wr_last (wr_last[g]),
      .rd_last (rd_last[g]),
      .rd_data (rd_data[g]),
      .rd_idx  (rd_idx[g])
    );
  end

`ifdef RHO_INV_PINGPONG_EN
  logic wsel;
  logic rsel;

  always_comb begin
    wr_en       = '0;
    rd_en       = '0;
    wr_en[wsel] = in_fire;
    rd_en[rsel] = out_fire;
  end

  assign in_ready = !emit[wsel];
  assign sel_emit = emit[rsel];
  assign sel_data = rd_data[rsel];
  assign sel_idx  = rd_idx[rsel];

  // write and read pointers hop banks independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else if (flush) begin
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else begin
      if (in_fire && wr_last[wsel]) wsel <= !wsel;
      if (out_fire && rd_last[rsel]) rsel <= !rsel;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^{wr_last, rd_last};
  assign wr_en    = in_fire;
  assign rd_en    = out_fire;
  assign in_ready = !emit[0];
  assign sel_emit = emit[0];
  assign sel_data = rd_data[0];
  assign sel_idx  = rd_idx[0];
`endif

  assign out_valid = sel_emit;
  assign out_data  = sel_emit ? sel_data : '0;
  assign out_idx   = sel_emit ? sel_idx : 2'd0;
  assign out_last  = sel_emit && (sel_idx == 2'd3);

endmodule
